// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light monitor: fault codes, FSM
// encoding, sample classes and the one-hot-to-lane helper.
package traffic_pkg;

   localparam int NUM_LANES = 4;

   // Fault codes reported on fault_code
   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_ILLEGAL = 3'd1;
   localparam logic [2:0] FC_ORDER   = 3'd2;
   localparam logic [2:0] FC_SHORT   = 3'd3;
   localparam logic [2:0] FC_STUCK   = 3'd4;

   // Monitor FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   // Per-cycle lamp sample classification
   typedef enum logic [1:0] {
      SMP_DARK    = 2'd0,
      SMP_VALID   = 2'd1,
      SMP_ILLEGAL = 2'd2
   } smp_t;

   // Lane index of a one-hot green vector (result is meaningless otherwise)
   function automatic logic [1:0] onehot_to_lane(input logic [NUM_LANES-1:0] v);
      logic [1:0] l;
      l = 2'd0;
      for (int i = 0; i < NUM_LANES; i++)
         if (v[i]) l = l | 2'(i);
      return l;
   endfunction

endpackage

// File: rtl/tlm_lamp_decode.sv
// Combinational lamp decoder: classifies an r/g sample and extracts the
// lane index of the green lamp.
module tlm_lamp_decode
   import traffic_pkg::*;
(
   input  logic [NUM_LANES-1:0] r,
   input  logic [NUM_LANES-1:0] g,
   output smp_t                 cls,
   output logic [1:0]           lane
);

   logic dark;
   logic onehot;

   assign dark   = (r == '0) && (g == '0);
   assign onehot = (g != '0) && ((g & (g - 4'd1)) == '0);
   assign lane   = onehot_to_lane(g);

   // A valid sample has exactly one green and every other lane red
   always_comb begin
      cls = SMP_ILLEGAL;
      if (dark)                      cls = SMP_DARK;
      else if (onehot && (r == ~g))  cls = SMP_VALID;
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Lamp bus safety monitor: tracks the 0->1->2->3 green rotation, checks
// dwell limits, latches the first violation and counts full rotations.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int DWELL_MIN = 11,
   parameter int DWELL_MAX = 11,
   parameter int CW        = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_LANES-1:0] r,
   input  logic [NUM_LANES-1:0] g,
   input  logic                 clr_fault,
   output logic                 fault,
   output logic [2:0]           fault_code,
   output logic [1:0]           cur_lane,
   output logic                 lane_valid,
   output logic [15:0]          cycle_count
);

   localparam logic [CW-1:0] DMIN = CW'(DWELL_MIN);
   localparam logic [CW-1:0] DMAX = CW'(DWELL_MAX);

   smp_t        cls;
   logic [1:0]  smp_lane;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] dwell_q, dwell_d;
   logic [1:0]    lane_q,  lane_d;
   logic          lv_q,    lv_d;
   logic          fault_q, fault_d;
   logic [2:0]    code_q,  code_d;
   logic [15:0]   cnt_q,   cnt_d;

   logic          trip;
   logic [2:0]    trip_code;

   tlm_lamp_decode u_dec (
      .r    (r),
      .g    (g),
      .cls  (cls),
      .lane (smp_lane)
   );

   // Next-state logic; any violation funnels through trip into FAULT
   always_comb begin
      state_d   = state_q;
      dwell_d   = dwell_q;
      lane_d    = lane_q;
      lv_d      = lv_q;
      fault_d   = fault_q;
      code_d    = code_q;
      cnt_d     = cnt_q;
      trip      = 1'b0;
      trip_code = FC_NONE;

      case (state_q)
         ST_IDLE: begin
            // Only a lane-0 green starts tracking; other greens are skipped
            if (cls == SMP_ILLEGAL) begin
               trip      = 1'b1;
               trip_code = FC_ILLEGAL;
            end else if (cls == SMP_VALID && smp_lane == 2'd0) begin
               state_d = ST_TRACK;
               lane_d  = 2'd0;
               dwell_d = CW'(1);
               lv_d    = 1'b1;
            end
         end
         ST_TRACK: begin
            if (cls == SMP_ILLEGAL) begin
               trip      = 1'b1;
               trip_code = FC_ILLEGAL;
            end else if (cls == SMP_DARK) begin
               // Controller went dark: treat as its reset, no fault
               state_d = ST_IDLE;
               dwell_d = '0;
               lane_d  = 2'd0;
               lv_d    = 1'b0;
            end else if (smp_lane == lane_q) begin
               if (dwell_q == DMAX) begin
                  trip      = 1'b1;
                  trip_code = FC_STUCK;
               end else begin
                  dwell_d = dwell_q + CW'(1);
               end
            end else if (smp_lane == lane_q + 2'd1) begin
               if (dwell_q < DMIN) begin
                  trip      = 1'b1;
                  trip_code = FC_SHORT;
               end else begin
                  lane_d  = smp_lane;
                  dwell_d = CW'(1);
                  if (lane_q == 2'd3) cnt_d = cnt_q + 16'd1;
               end
            end else begin
               trip      = 1'b1;
               trip_code = FC_ORDER;
            end
         end
         ST_FAULT: begin
            // Inputs ignored; only an explicit clear leaves FAULT
            if (clr_fault) begin
               state_d = ST_IDLE;
               fault_d = 1'b0;
               code_d  = FC_NONE;
               dwell_d = '0;
               lane_d  = 2'd0;
               lv_d    = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            dwell_d = '0;
            lv_d    = 1'b0;
         end
      endcase

      if (trip) begin
         state_d = ST_FAULT;
         fault_d = 1'b1;
         code_d  = trip_code;
         dwell_d = '0;
         lv_d    = 1'b0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         dwell_q <= '0;
         lane_q  <= 2'd0;
         lv_q    <= 1'b0;
         fault_q <= 1'b0;
         code_q  <= FC_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         lane_q  <= lane_d;
         lv_q    <= lv_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fault       = fault_q;
   assign fault_code  = code_q;
   assign cur_lane    = lane_q;
   assign lane_valid  = lv_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor. Each step pushes the expected
// outputs to a scoreboard queue, then pops and compares after the edge.
module tb_traffic_light_monitor;

   logic        clk;
   logic        rst;
   logic [3:0]  r;
   logic [3:0]  g;
   logic        clr_fault;
   logic        fault;
   logic [2:0]  fault_code;
   logic [1:0]  cur_lane;
   logic        lane_valid;
   logic [15:0] cycle_count;

   typedef struct packed {
      logic        f;
      logic [2:0]  c;
      logic [1:0]  l;
      logic        v;
      logic [15:0] n;
      logic        cl;   // compare cur_lane on this step
   } exp_t;

   exp_t sbq[$];

   int checks = 0;
   int errors = 0;

   logic        e_fault;
   logic [2:0]  e_code;
   logic [1:0]  e_lane;
   logic        e_lv;
   logic [15:0] e_cnt;

   traffic_light_monitor dut (
      .clk         (clk),
      .rst         (rst),
      .r           (r),
      .g           (g),
      .clr_fault   (clr_fault),
      .fault       (fault),
      .fault_code  (fault_code),
      .cur_lane    (cur_lane),
      .lane_valid  (lane_valid),
      .cycle_count (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_e(input logic f, input logic [2:0] c, input logic [1:0] l,
                        input logic v, input logic [15:0] n);
      e_fault = f; e_code = c; e_lane = l; e_lv = v; e_cnt = n;
   endtask

   task automatic compare(input string tag);
      exp_t ex;
      ex = sbq.pop_front();
      checks++;
      assert (fault === ex.f) else begin
         errors++;
         $error("FAIL %s fault got %0b exp %0b", tag, fault, ex.f);
      end
      checks++;
      assert (fault_code === ex.c) else begin
         errors++;
         $error("FAIL %s fault_code got %0d exp %0d", tag, fault_code, ex.c);
      end
      checks++;
      assert (lane_valid === ex.v) else begin
         errors++;
         $error("FAIL %s lane_valid got %0b exp %0b", tag, lane_valid, ex.v);
      end
      checks++;
      assert (cycle_count === ex.n) else begin
         errors++;
         $error("FAIL %s cycle_count got %0d exp %0d", tag, cycle_count, ex.n);
      end
      if (ex.cl) begin
         checks++;
         assert (cur_lane === ex.l) else begin
            errors++;
            $error("FAIL %s cur_lane got %0d exp %0d", tag, cur_lane, ex.l);
         end
      end
   endtask

   task automatic step(input logic [3:0] rr, input logic [3:0] gg, input logic clr,
                       input string tag);
      exp_t e;
      r = rr; g = gg; clr_fault = clr;
      e.f = e_fault; e.c = e_code; e.l = e_lane; e.v = e_lv; e.n = e_cnt;
      e.cl = e_lv || !rst;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   // Hold a legal green on one lane for n samples
   task automatic hold(input int ln, input int n, input string tag);
      logic [3:0] gv;
      gv = 4'b0001 << ln;
      for (int i = 0; i < n; i++) step(~gv, gv, 1'b0, tag);
   endtask

   task automatic trk(input int ln, input logic [15:0] cnt, input int n, input string tag);
      set_e(1'b0, 3'd0, 2'(ln), 1'b1, cnt);
      hold(ln, n, tag);
   endtask

   initial begin
      rst = 1'b0; r = '0; g = '0; clr_fault = 1'b0;

      // Reset state, even with garbage on the bus
      set_e(0, 0, 0, 0, 0);
      step(4'h0, 4'h0, 0, "reset");
      step(4'hF, 4'hF, 0, "reset_garbage");
      rst = 1'b1;

      // Reference sequence: dark start then three full rotations
      step(4'h0, 4'h0, 0, "dark_start");
      for (int rot = 0; rot < 3; rot++)
         for (int ln = 0; ln < 4; ln++)
            trk(ln, 16'(rot), 11, "rotation");
      trk(0, 16'd3, 11, "rotation_wrap");

      // Two greens at once: ILLEGAL, code sticks
      set_e(1, 3'd1, 0, 0, 3);
      step(4'b1100, 4'b0011, 0, "illegal");
      step(4'b1011, 4'b0100, 0, "illegal_hold");
      step(4'b0000, 4'b0000, 0, "illegal_hold_dark");
      step(4'b1110, 4'b0001, 0, "illegal_hold_l0");
      set_e(0, 0, 0, 0, 3);
      step(4'h0, 4'h0, 1, "clear1");

      // Skip lane 1: ORDER
      trk(0, 16'd3, 11, "order_l0");
      set_e(1, 3'd2, 0, 0, 3);
      step(4'b1011, 4'b0100, 0, "order");
      step(4'h0, 4'h0, 0, "order_hold");
      set_e(0, 0, 0, 0, 3);
      step(4'h0, 4'h0, 1, "clear2");

      // Lane 1 only 7 cycles: SHORT
      trk(0, 16'd3, 11, "short_l0");
      trk(1, 16'd3, 7, "short_l1");
      set_e(1, 3'd3, 1, 0, 3);
      step(4'b1011, 4'b0100, 0, "short");
      set_e(0, 0, 0, 0, 3);
      step(4'h0, 4'h0, 1, "clear3");

      // Lane 2 held 12 cycles: STUCK on the 12th sample
      trk(0, 16'd3, 11, "stuck_l0");
      trk(1, 16'd3, 11, "stuck_l1");
      trk(2, 16'd3, 11, "stuck_l2");
      set_e(1, 3'd4, 2, 0, 3);
      step(4'b1011, 4'b0100, 0, "stuck");
      set_e(0, 0, 0, 0, 3);
      step(4'h0, 4'h0, 1, "clear4");

      // IDLE ignores non-lane-0 greens, then lane 0 starts tracking
      set_e(0, 0, 0, 0, 3);
      hold(2, 11, "idle_l2");
      trk(0, 16'd3, 10, "resync_l0");
      step(4'b1110, 4'b0001, 1, "clr_in_track");

      // Run up to cycle_count=5 then reset mid-rotation
      trk(1, 16'd3, 11, "run");
      trk(2, 16'd3, 11, "run");
      trk(3, 16'd3, 11, "run");
      trk(0, 16'd4, 11, "run");
      trk(1, 16'd4, 11, "run");
      trk(2, 16'd4, 11, "run");
      trk(3, 16'd4, 11, "run");
      trk(0, 16'd5, 3, "run5");
      rst = 1'b0;
      set_e(0, 0, 0, 0, 0);
      step(4'b1110, 4'b0001, 0, "mid_reset");
      rst = 1'b1;
      hold(1, 2, "post_reset_l1");
      trk(0, 16'd0, 2, "post_reset_l0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Safety monitor on the receiving end of the four-lane traffic light controller's lamp bus. Samples the red and green lamp vectors every cycle and checks lamp legality, lane rotation order and green dwell time. Latches the first violation as a fault code and counts completed rotations. Sits beside the controller and feeds the intersection fail-safe logic.

## Interface
- DWELL_MIN, default 11: minimum consecutive cycles a green must be sampled before a legal hand-off.
- DWELL_MAX, default 11: maximum consecutive cycles a green may be sampled.
- CW, default 8: dwell counter width; DWELL_MAX < 2^CW - 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- r  input  4  red lamps, bit i = lane i.
- g  input  4  green lamps, bit i = lane i.
- clr_fault  input  1  single-cycle fault clear; honoured only in FAULT.
- fault  output  1  latched violation flag.
- fault_code  output  3  0 NONE, 1 ILLEGAL, 2 ORDER, 3 SHORT, 4 STUCK.
- cur_lane  output  2  index of the lane currently green while tracking.
- lane_valid  output  1  high while in TRACK.
- cycle_count  output  16  completed 0→1→2→3→0 rotations; wraps modulo 2^16.

## Operation
- Per-cycle sample classification:
  - DARK: r==0 and g==0.
  - VALID: g one-hot and r == ~g.
  - ILLEGAL: anything else, including two greens or a red and green on the same lane.
- States: IDLE, TRACK, FAULT.
- IDLE:
  - DARK, or VALID with g≠4'b0001: stay in IDLE. Non-lane-0 greens are ignored here to resynchronise.
  - VALID g==4'b0001: go to TRACK with cur_lane=0 and dwell=1.
  - ILLEGAL: go to FAULT, code ILLEGAL.
- TRACK, in priority order:
  - ILLEGAL → FAULT, code ILLEGAL.
  - DARK → IDLE, no fault. This is a controller reset.
  - Same green with dwell==DWELL_MAX → FAULT, code STUCK. Otherwise same green increments dwell.
  - Green on lane (cur_lane+1) mod 4:
    - dwell < DWELL_MIN → FAULT, code SHORT.
    - Otherwise update cur_lane and set dwell=1.
    - On a 3→0 hand-off, cycle_count increments.
  - Green on any other lane → FAULT, code ORDER.
- FAULT:
  - fault=1; fault_code holds the first violation. Later violations do not overwrite it.
  - Inputs are ignored.
  - clr_fault=1 → IDLE with fault=0, fault_code=0, dwell=0, lane_valid=0. cycle_count is preserved.
  - clr_fault outside FAULT has no effect.
- Dwell counter is CW bits and never exceeds DWELL_MAX, so it never wraps.

## Timing
- All outputs are registered. Reset value of every output is 0.
- rst low at any clock edge, mid-rotation or in FAULT, forces reset values at that edge. This includes cycle_count.
- Latency is one cycle: a violation sampled at edge N shows fault=1 and a valid fault_code from edge N, visible after N.
- cur_lane and lane_valid update on the same edge as the hand-off sample.
- With default parameters each green must be sampled exactly 11 consecutive cycles, matching the controller's hold.
- The controller's single-cycle all-dark start state is DARK and accepted in IDLE.

## Structure
- Shared package traffic_pkg holds:
  - fault code constants (NONE, ILLEGAL, ORDER, SHORT, STUCK);
  - monitor state encoding;
  - lane count constant 4;
  - a function converting a one-hot green vector to a lane index.
- One combinational sub-module, tlm_lamp_decode, takes r/g and produces DARK/VALID/ILLEGAL plus the lane index. The top holds the FSM, dwell counter and rotation counter.

## Test plan
- Drive the reference sequence: 1 dark cycle, then lanes 0,1,2,3 each 11 cycles, repeated 3 times → fault stays 0, cycle_count=3, cur_lane follows 0,1,2,3 on each hand-off edge.
- In TRACK, present g=4'b0011, r=4'b1100 → one cycle later fault=1, fault_code=1. Subsequent samples do not change the code.
- Lane 0 held 11 cycles, then g=4'b0100 (skips lane 1) → fault_code=2. Then clr_fault pulse → IDLE, fault=0, cycle_count unchanged.
- Lane 1 held only 7 cycles before lane 2 → fault_code=3. Lane 2 held 12 cycles → fault_code=4 on the 12th sample.
- In IDLE, present lane 2 green for 11 cycles → stays IDLE, lane_valid=0, no fault. Lane 0 green arrives → lane_valid=1, cur_lane=0.
- Assert rst=0 for one edge mid-rotation with cycle_count=5 → all outputs 0 at that edge, then the monitor resynchronises on the next lane-0 green.
